// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program image into instr_mem and sequences the core reset
// around the load (hold in reset while loading, release after a fixed hold time).
module imem_boot_loader #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 12,
    parameter int MAX_WORDS         = 256,
    parameter int BASE_ADDR         = 0,
    parameter int RESET_HOLD_CYCLES = 3
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_start,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   i_word_count,
    input  logic                             i_s_valid,
    input  logic [DATA_WIDTH-1:0]            i_s_data,
    output logic                             o_s_ready,
    output logic                             o_mem_we,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    output logic [DATA_WIDTH-1:0]            o_mem_wdata,
    output logic                             o_cpu_reset_n,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error
);

    localparam int CNT_W  = $clog2(MAX_WORDS + 1);
    localparam int STRIDE = DATA_WIDTH / 8;
    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STRIDE);
    localparam logic [HOLD_W-1:0]     HOLD_END = HOLD_W'(RESET_HOLD_CYCLES - 1);

    generate
        if (longint'(BASE_ADDR) + longint'(MAX_WORDS) * longint'(STRIDE)
                > (longint'(1) << ADDR_WIDTH)) begin : g_range_check
            $fatal(1, "imem_boot_loader: image does not fit in ADDR_WIDTH address space");
        end
        if ((BASE_ADDR % STRIDE) != 0) begin : g_align_check
            $fatal(1, "imem_boot_loader: BASE_ADDR is not word aligned");
        end
        if (RESET_HOLD_CYCLES < 1) begin : g_hold_check
            $fatal(1, "imem_boot_loader: RESET_HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        remaining;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    vld_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic [DATA_WIDTH-1:0]   wdata_p1;
    logic                    cpu_run;
    logic                    error_q;
    logic                    count_bad;

    assign count_bad = (i_word_count > CNT_W'(MAX_WORDS));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            hold_cnt  <= '0;
            next_addr <= BASE;
            vld_p1    <= 1'b0;
            addr_p1   <= BASE;
            wdata_p1  <= '0;
            cpu_run   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                // IDLE and RUN share start handling; an illegal count never disturbs a running core.
                IDLE, RUN: begin
                    if (i_start) begin
                        if (count_bad) begin
                            error_q <= 1'b1;
                        end else begin
                            error_q   <= 1'b0;
                            cpu_run   <= 1'b0;
                            next_addr <= BASE;
                            hold_cnt  <= '0;
                            remaining <= i_word_count;
                            state     <= (i_word_count == '0) ? HOLD : LOAD;
                        end
                    end
                end
                // Accepted beat -> write stage one cycle later
                LOAD: begin
                    if (i_s_valid) begin
                        vld_p1    <= 1'b1;
                        addr_p1   <= next_addr;
                        wdata_p1  <= i_s_data;
                        next_addr <= next_addr + STEP;
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HOLD_END) begin
                        state   <= RUN;
                        cpu_run <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_s_ready     = (state == LOAD);
    assign o_busy        = (state == LOAD) || (state == HOLD);
    assign o_done        = (state == RUN);
    assign o_mem_we      = vld_p1;
    assign o_mem_addr    = addr_p1;
    assign o_mem_wdata   = wdata_p1;
    assign o_cpu_reset_n = cpu_run;
    assign o_error       = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of load scenarios plus hand-written corner sequences,
// with a write scoreboard filled as beats are accepted and drained on each write strobe.
module tb_imem_boot_loader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MW = 256;
    localparam int CW = $clog2(MW + 1);

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_start;
    logic [CW-1:0] i_word_count;
    logic          i_s_valid;
    logic [DW-1:0] i_s_data;
    logic          o_s_ready;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic          o_cpu_reset_n;
    logic          o_busy;
    logic          o_done;
    logic          o_error;

    always #5 i_clk = ~i_clk;

    imem_boot_loader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MW),
        .BASE_ADDR(0), .RESET_HOLD_CYCLES(3)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_word_count(i_word_count), .i_s_valid(i_s_valid), .i_s_data(i_s_data),
        .o_s_ready(o_s_ready), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_cpu_reset_n(o_cpu_reset_n), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int          count;
        logic [15:0] pat;
        int          plen;
        bit          do_rst;
        bit          exp_err;
        int          exp_strobes;
        bit          exp_run;
    } vec_t;

    wr_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  n_strobes = 0;
    int  last_strobe_cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write-port monitor: every strobe must match the oldest accepted beat
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_reset_n === 1'b1 && o_mem_we === 1'b1) begin
                n_strobes++;
                last_strobe_cyc = cyc;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got write to 0x%0h, want no write", o_mem_addr);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("strobe_addr", 64'(o_mem_addr), 64'(e.addr));
                    check("strobe_data", 64'(o_mem_wdata), 64'(e.data));
                end
            end
        end
    end

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_start = 1'b0;
        i_s_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        sb.delete();
        i_reset_n = 1'b1;
    endtask

    task automatic run_load(input int count, input logic [15:0] pat, input int plen,
                            input int nbeats, input logic [DW-1:0] seed, input bit inject);
        int n;
        int k;
        n = 0;
        k = 0;
        @(negedge i_clk);
        i_start = 1'b1;
        i_word_count = CW'(count);
        @(negedge i_clk);
        i_start = 1'b0;
        i_word_count = '0;
        if (count <= MW) begin
            check("cpu_reset_after_start", 64'(o_cpu_reset_n), 64'(0));
        end
        check("ready_after_start", 64'(o_s_ready), 64'(count > 0 && count <= MW));
        if (count == 0 || count > MW) return;
        while (n < nbeats && k < 1000) begin
            i_s_valid = pat[k % plen];
            i_s_data = seed + DW'(n + 1);
            if (inject && k == 1) begin
                i_start = 1'b1;
                i_word_count = CW'(5);
            end else begin
                i_start = 1'b0;
            end
            if (i_s_valid && o_s_ready) begin
                sb.push_back('{AW'(n * 4), seed + DW'(n + 1)});
                n++;
            end
            k++;
            @(negedge i_clk);
        end
        i_s_valid = 1'b0;
        i_start = 1'b0;
        check("load_beats_accepted", 64'(n), 64'(nbeats));
    endtask

    task automatic wait_run(output int rel);
        rel = -1;
        for (int i = 0; i < 30; i++) begin
            if (o_cpu_reset_n === 1'b1) begin
                rel = cyc;
                break;
            end
            @(negedge i_clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[7];
        int   rel;

        vt[0] = '{8,   16'h0001, 1, 1'b1, 1'b0, 8,   1'b1};
        vt[1] = '{4,   16'h0059, 7, 1'b1, 1'b0, 4,   1'b1};
        vt[2] = '{0,   16'h0001, 1, 1'b1, 1'b0, 0,   1'b1};
        vt[3] = '{257, 16'h0001, 1, 1'b1, 1'b1, 0,   1'b0};
        vt[4] = '{1,   16'h0001, 1, 1'b0, 1'b0, 1,   1'b1};
        vt[5] = '{5,   16'h0005, 3, 1'b1, 1'b0, 5,   1'b1};
        vt[6] = '{256, 16'h0001, 1, 1'b1, 1'b0, 256, 1'b1};

        i_reset_n = 1'b0;
        i_start = 1'b0;
        i_word_count = '0;
        i_s_valid = 1'b0;
        i_s_data = '0;
        #12;
        check("rst_ready", 64'(o_s_ready), 64'(0));
        check("rst_we", 64'(o_mem_we), 64'(0));
        check("rst_addr", 64'(o_mem_addr), 64'(0));
        check("rst_wdata", 64'(o_mem_wdata), 64'(0));
        check("rst_cpu_reset_n", 64'(o_cpu_reset_n), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_error", 64'(o_error), 64'(0));
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            logic [DW-1:0] seed;
            seed = 32'hA500_0000 + (DW'(i) << 16);
            if (vt[i].do_rst) do_reset();
            n_strobes = 0;
            run_load(vt[i].count, vt[i].pat, vt[i].plen,
                     (vt[i].count > MW) ? 0 : vt[i].count, seed, 1'b0);
            if (vt[i].exp_run) begin
                wait_run(rel);
                check("reached_run", 64'(rel >= 0), 64'(1));
                if (vt[i].count > 0) begin
                    check("release_delay", 64'(rel - last_strobe_cyc), 64'(3));
                end
                check("run_done", 64'(o_done), 64'(1));
                check("run_busy", 64'(o_busy), 64'(0));
            end else begin
                repeat (3) @(negedge i_clk);
                check("err_ready", 64'(o_s_ready), 64'(0));
                check("err_cpu_reset_n", 64'(o_cpu_reset_n), 64'(0));
                check("err_done", 64'(o_done), 64'(0));
            end
            check("vec_error", 64'(o_error), 64'(vt[i].exp_err));
            check("vec_strobes", 64'(n_strobes), 64'(vt[i].exp_strobes));
            check("vec_sb_empty", 64'(sb.size()), 64'(0));
        end

        // Zero-length image: exactly three busy cycles, then run
        do_reset();
        @(negedge i_clk);
        i_start = 1'b1;
        i_word_count = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("zero_busy", 64'(o_busy), 64'(1));
            check("zero_cpu_held", 64'(o_cpu_reset_n), 64'(0));
            @(negedge i_clk);
        end
        check("zero_done", 64'(o_done), 64'(1));
        check("zero_cpu_run", 64'(o_cpu_reset_n), 64'(1));

        // Async reset after three of eight beats, then a fresh two-word load
        do_reset();
        n_strobes = 0;
        run_load(8, 16'h0001, 1, 3, 32'hC0DE_0000, 1'b0);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("arst_ready", 64'(o_s_ready), 64'(0));
        check("arst_we", 64'(o_mem_we), 64'(0));
        check("arst_addr", 64'(o_mem_addr), 64'(0));
        check("arst_wdata", 64'(o_mem_wdata), 64'(0));
        check("arst_cpu_reset_n", 64'(o_cpu_reset_n), 64'(0));
        check("arst_busy", 64'(o_busy), 64'(0));
        check("arst_strobes", 64'(n_strobes), 64'(3));
        check("arst_sb_empty", 64'(sb.size()), 64'(0));
        @(negedge i_clk);
        i_reset_n = 1'b1;
        run_load(2, 16'h0001, 1, 2, 32'hBEEF_0000, 1'b0);
        wait_run(rel);
        check("reload_release", 64'(rel - last_strobe_cyc), 64'(3));
        check("reload_strobes", 64'(n_strobes), 64'(5));

        // Reload while running, with a stray start during LOAD
        n_strobes = 0;
        run_load(2, 16'h0001, 1, 2, 32'h1234_0000, 1'b1);
        wait_run(rel);
        check("run_reload_release", 64'(rel - last_strobe_cyc), 64'(3));
        check("run_reload_strobes", 64'(n_strobes), 64'(2));
        check("run_reload_error", 64'(o_error), 64'(0));

        // Illegal count while running: flag error, core keeps running
        run_load(257, 16'h0001, 1, 0, 32'h0, 1'b0);
        repeat (2) @(negedge i_clk);
        check("run_bad_error", 64'(o_error), 64'(1));
        check("run_bad_cpu", 64'(o_cpu_reset_n), 64'(1));
        check("run_bad_done", 64'(o_done), 64'(1));
        check("run_bad_strobes", 64'(n_strobes), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
